// File: rtl/match_event_logger.sv
// Timestamps match pulses against a free-running counter and queues them in a FIFO drained over valid/ready.
// Optional minimum-spacing filter on accepted matches: define MATCH_GAP_FILTER_EN.
module match_event_logger #(
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int MIN_GAP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       match_in,
  input  logic                       clear,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_data,
  output logic [CNT_W-1:0]           match_count,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            accept;
  logic            push;
  logic            pop;

  // Free-running timestamp; a soft clear deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

`ifdef MATCH_GAP_FILTER_EN
  localparam int GW = $clog2(MIN_GAP + 1);
  logic [GW-1:0] gap_cnt;

  // Starts saturated so the first match after reset or clear always passes.
  always_ff @(posedge clk) begin
    if (!rst_n || clear)               gap_cnt <= GW'(MIN_GAP);
    else if (accept)                   gap_cnt <= GW'(1);
    else if (gap_cnt < GW'(MIN_GAP))   gap_cnt <= gap_cnt + GW'(1);
  end

  assign accept = match_in & ~clear & (gap_cnt >= GW'(MIN_GAP));
`else
  assign accept = match_in & ~clear;
`endif

  assign evt_valid = (fifo_level != '0);
  assign pop       = evt_valid & evt_ready;
  assign push      = accept & ((fifo_level < LW'(DEPTH)) | pop);
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

  // FIFO control, counter and sticky flag
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (accept)         match_count <= sat_inc(match_count);
      if (accept && !push) overflow   <= 1'b1;
    end
  end

  // Storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= ts;
  end

endmodule
